// File: rtl/r22sdf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | r22sdf_pkg : FSM encodings and index helpers for the R22SDF reorder stage |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package r22sdf_pkg;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_FILL = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RUN  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

  // Reverses the low aw bits of v; bits at and above aw are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int aw);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < aw) r[5'(k)] = v[5'(aw - 1 - k)];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/r22sdf_dpram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | r22sdf_dpram : simple dual-port RAM, one write port, registered read     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module r22sdf_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/r22sdf_bitrev_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | r22sdf_bitrev_reorder : ping-pong bit-reversed to natural order reorder  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module r22sdf_bitrev_reorder
  import r22sdf_pkg::*;
#(
  parameter  int data_resolution = 16,
  parameter  int fft_length      = 16384,
  localparam int AW              = clog2(fft_length)
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       din_vld,
  input  logic                       din_sop,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic                       dout_vld,
  output logic                       dout_sop,
  output logic                       dout_eop,
  output logic [AW-1:0]              dout_idx,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       sop_err,
  output logic                       ovf_err
);

  localparam int            DW   = 2 * data_resolution;
  localparam logic [AW-1:0] LAST = AW'(fft_length - 1);

  logic [0:0]    wr_state;
  logic [AW-1:0] wr_cnt;
  logic          wr_bank;
  logic [AW-1:0] wr_rev;
  logic          wr_start;
  logic          wr_restart;
  logic          wr_last;
  logic          wr_ovf;
  logic          wr_busy;

  logic [0:0]    rd_state;
  logic [AW-1:0] rd_cnt;
  logic          rd_bank;
  logic          rd_issue;
  logic          rd_done;

  logic [1:0]    full;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  logic          ram_we;
  logic [AW:0]   ram_waddr;
  logic [AW:0]   ram_raddr;
  logic [DW-1:0] ram_rdata;

  logic          s1_vld;
  logic [AW-1:0] s1_idx;

  assign wr_rev    = AW'(bitrev(32'(wr_cnt), AW));
  assign rd_issue  = (rd_state == R_RUN);
  assign rd_done   = rd_issue && (rd_cnt == LAST);
  assign ram_raddr = {rd_bank, rd_cnt};

  // A bank whose last address is issued this cycle is already free, which is
  // what lets a new frame start directly behind two back-to-back frames.
  assign wr_busy  = full[wr_bank] && !(rd_done && (rd_bank == wr_bank));
  assign full_set = wr_last ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;

  always_comb begin
    wr_start   = 1'b0;
    wr_restart = 1'b0;
    wr_last    = 1'b0;
    wr_ovf     = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = {wr_bank, wr_rev};
    if (wr_state == W_IDLE) begin
      if (din_vld && din_sop) begin
        wr_ovf    = wr_busy;
        wr_start  = !wr_busy;
        ram_we    = !wr_busy;
        ram_waddr = {wr_bank, {AW{1'b0}}};
      end
    end else if (din_vld) begin
      ram_we     = 1'b1;
      wr_restart = din_sop;
      wr_last    = !din_sop && (wr_cnt == LAST);
      if (din_sop) ram_waddr = {wr_bank, {AW{1'b0}}};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      sop_err  <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      sop_err <= wr_restart;
      ovf_err <= wr_ovf;
      if (wr_start || wr_restart) begin
        wr_state <= W_FILL;
        wr_cnt   <= AW'(1);
      end else if (wr_last) begin
        wr_state <= W_IDLE;
        wr_cnt   <= '0;
        wr_bank  <= ~wr_bank;
      end else if ((wr_state == W_FILL) && din_vld) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) full <= '0;
    else           full <= (full | full_set) & ~full_clr;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
    end else if (rd_state == R_IDLE) begin
      if (full[rd_bank]) begin
        rd_state <= R_RUN;
        rd_cnt   <= '0;
      end
    end else if (rd_done) begin
      rd_bank <= ~rd_bank;
      rd_cnt  <= '0;
      if (!full[~rd_bank]) rd_state <= R_IDLE;
    end else begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  r22sdf_dpram #(
    .DATA_W (DW),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk     (sys_clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data ({din_r, din_i}),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // s1_* tracks the RAM's registered read so the framing lines up with data.
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      s1_vld   <= 1'b0;
      s1_idx   <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_idx <= '0;
      dout_r   <= '0;
      dout_i   <= '0;
    end else begin
      s1_vld   <= rd_issue;
      s1_idx   <= rd_cnt;
      dout_vld <= s1_vld;
      dout_sop <= s1_vld && (s1_idx == '0);
      dout_eop <= s1_vld && (s1_idx == LAST);
      dout_idx <= s1_vld ? s1_idx : '0;
      dout_r   <= s1_vld ? ram_rdata[DW-1:data_resolution] : '0;
      dout_i   <= s1_vld ? ram_rdata[data_resolution-1:0] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_r22sdf_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_r22sdf_bitrev_reorder : self-checking bench, N=8 and N=16384 copies   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_r22sdf_bitrev_reorder;

  localparam int DR  = 16;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int NB  = 16384;
  localparam int AWB = 14;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic          din_vld = 1'b0, din_sop = 1'b0;
  logic [DR-1:0] din_r = '0, din_i = '0;
  logic          dout_vld, dout_sop, dout_eop, sop_err, ovf_err;
  logic [AW-1:0] dout_idx;
  logic [DR-1:0] dout_r, dout_i;

  logic           b_din_vld = 1'b0, b_din_sop = 1'b0;
  logic [DR-1:0]  b_din_r = '0, b_din_i = '0;
  logic           b_dout_vld, b_dout_sop, b_dout_eop, b_sop_err, b_ovf_err;
  logic [AWB-1:0] b_dout_idx;
  logic [DR-1:0]  b_dout_r, b_dout_i;

  r22sdf_bitrev_reorder #(.data_resolution(DR), .fft_length(N)) dut (
    .sys_clk(clk), .sys_nrst(nrst), .din_vld(din_vld), .din_sop(din_sop),
    .din_r(din_r), .din_i(din_i), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout_idx(dout_idx), .dout_r(dout_r), .dout_i(dout_i),
    .sop_err(sop_err), .ovf_err(ovf_err)
  );

  r22sdf_bitrev_reorder #(.data_resolution(DR), .fft_length(NB)) dut_big (
    .sys_clk(clk), .sys_nrst(nrst), .din_vld(b_din_vld), .din_sop(b_din_sop),
    .din_r(b_din_r), .din_i(b_din_i), .dout_vld(b_dout_vld), .dout_sop(b_dout_sop),
    .dout_eop(b_dout_eop), .dout_idx(b_dout_idx), .dout_r(b_dout_r), .dout_i(b_dout_i),
    .sop_err(b_sop_err), .ovf_err(b_ovf_err)
  );

  typedef struct {
    int            cyc;
    int            idx;
    logic [DR-1:0] r;
    logic [DR-1:0] i;
    logic          sop;
    logic          eop;
  } obs_t;

  int   checks = 0, errors = 0;
  int   cyc = 0, sop_err_cnt = 0, ovf_cnt = 0, last_cyc = 0;
  obs_t obs_q[$];
  obs_t big_q[$];
  logic [DR-1:0] fr_r[$];
  logic [DR-1:0] fr_i[$];
  logic [DR-1:0] big_i[NB];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_vld === 1'b1)
      obs_q.push_back('{cyc, int'(dout_idx), dout_r, dout_i, dout_sop, dout_eop});
    if (b_dout_vld === 1'b1)
      big_q.push_back('{cyc, int'(b_dout_idx), b_dout_r, b_dout_i, b_dout_sop, b_dout_eop});
    if (sop_err === 1'b1) sop_err_cnt++;
    if (ovf_err === 1'b1 || b_ovf_err === 1'b1) ovf_cnt++;
  end

  // Natural bin n of a frame holds the sample that arrived n-bit-reversed.
  function automatic int rev(input int v, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++)
      if ((v >> b) & 1) r |= 1 << (bits - 1 - b);
    return r;
  endfunction

  task automatic send_frame(input int gap);
    for (int k = 0; k < N; k++) begin
      din_vld = 1'b1;
      din_sop = (k == 0);
      din_r   = DR'($urandom);
      din_i   = DR'($urandom);
      fr_r.push_back(din_r);
      fr_i.push_back(din_i);
      @(posedge clk); #1;
      din_vld = 1'b0;
      din_sop = 1'b0;
      if (k != N - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    last_cyc = cyc;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b want 0", dout_vld); end
    checks++; if (dout_sop !== 1'b0) begin errors++; $display("FAIL rst_sop got %b want 0", dout_sop); end
    checks++; if (dout_eop !== 1'b0) begin errors++; $display("FAIL rst_eop got %b want 0", dout_eop); end
    checks++; if (dout_idx !== '0) begin errors++; $display("FAIL rst_idx got %0d want 0", dout_idx); end
    checks++; if (dout_r !== '0 || dout_i !== '0) begin errors++; $display("FAIL rst_data got %h/%h want 0/0", dout_r, dout_i); end
    checks++; if (sop_err !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b%b want 00", sop_err, ovf_err); end
    checks++; if (b_dout_vld !== 1'b0) begin errors++; $display("FAIL rst_big_vld got %b want 0", b_dout_vld); end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    obs_q.delete(); fr_r.delete(); fr_i.delete();
    for (int k = 0; k < N; k++) begin
      din_vld = 1'b1; din_sop = (k == 0); din_r = DR'(k); din_i = '0;
      fr_r.push_back(din_r); fr_i.push_back(din_i);
      @(posedge clk); #1;
    end
    din_vld = 1'b0; din_sop = 1'b0;
    last_cyc = cyc;
    for (int t = 0; t < 40 && obs_q.size() < N; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== N) begin errors++; $display("FAIL single_count got %0d want %0d", obs_q.size(), N); end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].cyc !== last_cyc + 3) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_q[0].cyc - last_cyc, 3); end
    end
    for (int p = 0; p < N && p < obs_q.size(); p++) begin
      checks++;
      if (obs_q[p].idx !== p || obs_q[p].r !== fr_r[rev(p, AW)] || obs_q[p].i !== fr_i[rev(p, AW)] ||
          obs_q[p].sop !== (p == 0) || obs_q[p].eop !== (p == N - 1)) begin
        errors++;
        $display("FAIL single_bin p=%0d got idx=%0d r=%0d sop=%b eop=%b want idx=%0d r=%0d sop=%b eop=%b",
                 p, obs_q[p].idx, obs_q[p].r, obs_q[p].sop, obs_q[p].eop, p, fr_r[rev(p, AW)], p == 0, p == N - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); fr_r.delete(); fr_i.delete(); ovf_cnt = 0; sop_err_cnt = 0;
    for (int f = 0; f < 3; f++) send_frame(0);
    for (int t = 0; t < 80 && obs_q.size() < 3 * N; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 3 * N) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), 3 * N); end
    checks++; if (ovf_cnt !== 0) begin errors++; $display("FAIL b2b_ovf got %0d want 0", ovf_cnt); end
    checks++; if (sop_err_cnt !== 0) begin errors++; $display("FAIL b2b_soperr got %0d want 0", sop_err_cnt); end
    for (int p = 0; p < 3 * N && p < obs_q.size(); p++) begin
      int src;
      src = (p / N) * N + rev(p % N, AW);
      checks++;
      if (obs_q[p].cyc !== obs_q[0].cyc + p || obs_q[p].idx !== p % N ||
          obs_q[p].r !== fr_r[src] || obs_q[p].i !== fr_i[src]) begin
        errors++;
        $display("FAIL b2b_bin p=%0d got cyc+%0d idx=%0d r=%h i=%h want cyc+%0d idx=%0d r=%h i=%h",
                 p, obs_q[p].cyc - obs_q[0].cyc, obs_q[p].idx, obs_q[p].r, obs_q[p].i, p, p % N, fr_r[src], fr_i[src]);
      end
    end
  endtask

  task automatic test_sop_err();
    obs_q.delete(); fr_r.delete(); fr_i.delete(); sop_err_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      din_vld = 1'b1; din_sop = (k == 0); din_r = DR'($urandom); din_i = DR'($urandom);
      @(posedge clk); #1;
    end
    send_frame(0);
    for (int t = 0; t < 40 && obs_q.size() < N; t++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (sop_err_cnt !== 1) begin errors++; $display("FAIL soperr_pulses got %0d want 1", sop_err_cnt); end
    checks++; if (obs_q.size() !== N) begin errors++; $display("FAIL soperr_count got %0d want %0d", obs_q.size(), N); end
    for (int p = 0; p < N && p < obs_q.size(); p++) begin
      checks++;
      if (obs_q[p].idx !== p || obs_q[p].r !== fr_r[rev(p, AW)] || obs_q[p].i !== fr_i[rev(p, AW)]) begin
        errors++;
        $display("FAIL soperr_bin p=%0d got idx=%0d r=%h i=%h want idx=%0d r=%h i=%h",
                 p, obs_q[p].idx, obs_q[p].r, obs_q[p].i, p, fr_r[rev(p, AW)], fr_i[rev(p, AW)]);
      end
    end
  endtask

  task automatic test_gapped();
    obs_q.delete(); fr_r.delete(); fr_i.delete();
    for (int f = 0; f < 2; f++) send_frame(1);
    for (int t = 0; t < 80 && obs_q.size() < 2 * N; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 2 * N) begin errors++; $display("FAIL gap_count got %0d want %0d", obs_q.size(), 2 * N); end
    for (int p = 0; p < 2 * N && p < obs_q.size(); p++) begin
      int src, base;
      src  = (p / N) * N + rev(p % N, AW);
      base = (p / N) * N;
      checks++;
      if (obs_q[p].cyc !== obs_q[base].cyc + (p % N) || obs_q[p].idx !== p % N ||
          obs_q[p].r !== fr_r[src] || obs_q[p].i !== fr_i[src]) begin
        errors++;
        $display("FAIL gap_bin p=%0d got cyc+%0d idx=%0d r=%h want cyc+%0d idx=%0d r=%h",
                 p, obs_q[p].cyc - obs_q[base].cyc, obs_q[p].idx, obs_q[p].r, p % N, p % N, fr_r[src]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n0;
    obs_q.delete(); fr_r.delete(); fr_i.delete();
    send_frame(0);
    for (int t = 0; t < 40 && obs_q.size() < 3; t++) @(posedge clk);
    #1;
    checks++; if (obs_q.size() < 3) begin errors++; $display("FAIL rstmid_start got %0d want >=3", obs_q.size()); end
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b want 0", dout_vld); end
    n0 = obs_q.size();
    repeat (30) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== n0) begin errors++; $display("FAIL rstmid_stale got %0d want %0d", obs_q.size() - n0, 0); end
    obs_q.delete(); fr_r.delete(); fr_i.delete();
    send_frame(0);
    for (int t = 0; t < 40 && obs_q.size() < N; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== N) begin errors++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), N); end
    for (int p = 0; p < N && p < obs_q.size(); p++) begin
      checks++;
      if (obs_q[p].idx !== p || obs_q[p].r !== fr_r[rev(p, AW)] || obs_q[p].i !== fr_i[rev(p, AW)]) begin
        errors++;
        $display("FAIL rstmid_bin p=%0d got idx=%0d r=%h want idx=%0d r=%h", p, obs_q[p].idx, obs_q[p].r, p, fr_r[rev(p, AW)]);
      end
    end
  endtask

  task automatic test_big_frame();
    int bad;
    big_q.delete();
    for (int k = 0; k < NB; k++) begin
      b_din_vld = 1'b1; b_din_sop = (k == 0); b_din_r = DR'(k); b_din_i = DR'($urandom);
      big_i[k] = b_din_i;
      @(posedge clk); #1;
    end
    b_din_vld = 1'b0; b_din_sop = 1'b0;
    for (int t = 0; t < NB + 100 && big_q.size() < NB; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (big_q.size() !== NB) begin errors++; $display("FAIL big_count got %0d want %0d", big_q.size(), NB); end
    if (big_q.size() == NB) begin
      checks++; if (big_q[1].r !== DR'(8192)) begin errors++; $display("FAIL big_bin1 got %0d want 8192", big_q[1].r); end
      checks++; if (big_q[NB-1].r !== DR'(NB - 1) || big_q[NB-1].eop !== 1'b1) begin
        errors++; $display("FAIL big_last got r=%0d eop=%b want r=%0d eop=1", big_q[NB-1].r, big_q[NB-1].eop, NB - 1);
      end
      checks++; if (big_q[0].sop !== 1'b1) begin errors++; $display("FAIL big_sop got %b want 1", big_q[0].sop); end
      bad = 0;
      for (int p = 0; p < NB; p++)
        if (big_q[p].idx !== p || big_q[p].r !== DR'(rev(p, AWB)) || big_q[p].i !== big_i[rev(p, AWB)] ||
            big_q[p].cyc !== big_q[0].cyc + p || big_q[p].eop !== (p == NB - 1)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL big_frame got %0d bad bins want 0", bad); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_sop_err();
    test_gapped();
    test_reset_mid_read();
    test_big_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
